// File: rtl/addsub_arbiter.sv
// addsub_arbiter: round-robin sharing of one external 8-bit add/sub unit between two requesters (optional ADDSUB_ARB_STATS_EN grant counters)
module addsub_arbiter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [7:0] req0_a,
  input  logic [7:0] req0_b,
  input  logic       req0_op,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [7:0] req1_a,
  input  logic [7:0] req1_b,
  input  logic       req1_op,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic       alu_op,
  input  logic [7:0] alu_sum,
  input  logic       alu_overflow,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_sum,
  output logic       rsp_overflow,
  output logic       rsp_id
`ifdef ADDSUB_ARB_STATS_EN
  ,
  output logic [7:0] grant_cnt0,
  output logic [7:0] grant_cnt1
`endif
);
  logic last, g0, g1, slot_free, acc;
  // grant the lone requester, or on a tie the one not served last; steer its operands to the unit
  always_comb begin
    slot_free = !rsp_valid || rsp_ready;
    g0 = req0_valid && (!req1_valid || last);
    g1 = req1_valid && (!req0_valid || !last);
    req0_ready = g0 && slot_free;
    req1_ready = g1 && slot_free;
    acc = req0_ready || req1_ready;
    alu_a = g0 ? req0_a : g1 ? req1_a : 8'h00;
    alu_b = g0 ? req0_b : g1 ? req1_b : 8'h00;
    alu_op = g0 ? req0_op : g1 ? req1_op : 1'b0;
  end
  // result register and round-robin pointer; accept overwrites, consume alone clears valid
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_sum <= 8'h00;
      rsp_overflow <= 1'b0;
      rsp_id <= 1'b0;
      last <= 1'b1;
    end else if (acc) begin
      rsp_valid <= 1'b1;
      rsp_sum <= alu_sum;
      rsp_overflow <= alu_overflow;
      rsp_id <= req1_ready;
      last <= req1_ready;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end
`ifdef ADDSUB_ARB_STATS_EN
  // saturating per-requester accept counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      grant_cnt0 <= 8'h00;
      grant_cnt1 <= 8'h00;
    end else begin
      grant_cnt0 <= grant_cnt0 + {7'd0, req0_ready && grant_cnt0 != 8'hff};
      grant_cnt1 <= grant_cnt1 + {7'd0, req1_ready && grant_cnt1 != 8'hff};
    end
  end
`endif
endmodule

// File: doc/addsub_arbiter.md
# addsub_arbiter

Round-robin arbiter and sequencer that shares one 8-bit carry-look-ahead add/subtract unit between two requesters. Each requester presents operands and an op bit over a valid/ready handshake. The block steers the winner's operands onto the shared unit and captures sum and overflow into a one-deep result register, which it returns to the requester with a requester tag. It sits between the client logic and the shared add/sub datapath; the datapath itself stays purely combinational and external.

## Interface

Parameters:
- none (width fixed at 8 to match the add/sub unit)

Ports:
- clk  input  1  rising-edge clock, sole clock domain
- rst_n  input  1  synchronous, active-low reset
- req0_valid  input  1  requester 0 has an operation pending
- req0_ready  output  1  requester 0 operation accepted this cycle
- req0_a, req0_b  input  8  requester 0 operands
- req0_op  input  1  requester 0 operation: 0 = a+b, 1 = a−b
- req1_valid, req1_ready, req1_a, req1_b, req1_op  (same as requester 0, for requester 1)
- alu_a, alu_b  output  8  operands driven to the shared add/sub unit
- alu_op  output  1  op driven to the shared unit
- alu_sum  input  8  shared unit result (combinational from alu_*)
- alu_overflow  input  1  shared unit signed overflow
- rsp_valid  output  1  result register holds a result
- rsp_ready  input  1  consumer takes the result
- rsp_sum  output  8  registered sum
- rsp_overflow  output  1  registered overflow
- rsp_id  output  1  requester that issued the result (0/1)

## Operation

- State: one-bit round-robin pointer `last` (last requester granted), result register {rsp_valid, rsp_sum, rsp_overflow, rsp_id}.
- slot_free = !rsp_valid || rsp_ready.
- Grant, combinational:
  - only reqN_valid high → N;
  - both high → requester ≠ last;
  - neither high → no grant.
- reqN_ready = grantN && slot_free. At most one ready is high per cycle.
- alu_a/alu_b/alu_op follow the granted requester. With no grant, all three are driven to 0.
- Accept (reqN_valid && reqN_ready):
  - result register loads alu_sum, alu_overflow and id N;
  - rsp_valid is set;
  - last ← N.
- Consume without accept: rsp_valid && rsp_ready && no accept → rsp_valid cleared. Data fields hold their last value.
- Simultaneous consume and accept in the same cycle: the register is overwritten with the new result and rsp_valid stays 1. No bubble.
- Requesters hold a, b, op stable while valid && !ready. The block does not latch operands.
- last changes only on an accept. An idle cycle does not move the pointer.

## Timing

- Reset, when rst_n is low at a clk edge:
  - rsp_valid=0, rsp_sum=0x00, rsp_overflow=0, rsp_id=0, last=1 (requester 0 wins the first tie);
  - req*_ready=0, because the grant needs valid and valid is assumed low during reset.
- Reset mid-operation discards any held result. No response is generated for an operation accepted in the reset cycle.
- Latency: accept at edge N → rsp_valid=1 with the result visible after edge N.
- Throughput: one operation per cycle while rsp_ready=1.
- Both requesters continuously valid with rsp_ready=1 → strict alternation 0,1,0,1… (starting with 0 after reset).
- Backpressure: rsp_valid=1 && rsp_ready=0 → both readies low. The result holds stable until consumed.
- Arithmetic is modulo 2^8; overflow is taken exactly as reported by the shared unit.

## Configuration

- ADDSUB_ARB_STATS_EN defined:
  - adds outputs grant_cnt0 and grant_cnt1 (8 bits each), counting accepts per requester;
  - each counter saturates at 0xFF and resets to 0x00.
- Not defined: the counters and ports do not exist. Arbitration behaviour is identical either way.

## Test plan

- Reset, then only req0: a=0x05, b=0x03, op=0 → req0_ready=1 in that cycle; next cycle rsp_valid=1, rsp_sum=0x08, rsp_overflow=0, rsp_id=0.
- req1 only: a=0x64, b=0x32, op=0 → rsp_sum=0x96, rsp_overflow=1, rsp_id=1. Then a=0x10, b=0x20, op=1 → rsp_sum=0xF0, rsp_overflow=0.
- Both valid for 4 cycles, rsp_ready=1 → rsp_id sequence 0,1,0,1; one result per cycle with no bubbles.
- Hold rsp_ready=0 for 3 cycles with both valid → both readies 0, rsp_* unchanged. Release → the held result is consumed and a new accept happens in the same cycle.
- Assert rst_n=0 for one cycle while rsp_valid=1 → rsp_valid=0, rsp_sum=0x00; the next tie is granted to requester 0.
- With ADDSUB_ARB_STATS_EN: 300 accepts from req0 → grant_cnt0=0xFF (saturated), grant_cnt1=0x00.
